// File: rtl/memory_stage_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
// req/we/addr/be/wdata are held by the master until ack or abort; ack is a
// single-cycle completion pulse that qualifies rdata.
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-bus loads/stores with timeout, branch redirect,
// RAW hazard stall towards execute, and the registered regfile write port.
module memory_stage #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  clk_en,
    input  logic [5:0]            ctr_in,
    input  logic [31:0]           inst_in,
    input  logic [31:0]           alu_in,
    input  logic [29:0]           inc_pc_in,
    input  logic [31:0]           rs2_data_in,
    input  logic                  branch_result_in,
    input  logic [4:0]            exe_rs1_address,
    input  logic [4:0]            exe_rs2_address,
    input  logic                  exe_uses_rs1,
    input  logic                  exe_uses_rs2,
    output logic                  invalidate,
    output logic                  stall,
    output logic                  pc_redirect,
    output logic [29:0]           pc_target,
    memory_stage_if.master        dbus,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  bus_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    // Everything the writeback of an outstanding access needs, captured at issue.
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [2:0]  fn3;
        logic [1:0]  wb_sel;
        logic [31:0] addr;
        logic [29:0] link;
    } mem_req_t;

    // Last BUSY cycle count before the access is abandoned (unused when BUS_TIMEOUT == 0).
    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state, state_nxt;
    mem_req_t    lat;
    logic        ack_flag;
    logic [31:0] ack_data;
    logic [7:0]  cnt;

    logic        valid, misaligned;
    logic        issue, ack_done, timeout, mis_err;
    logic [4:0]  in_rd;
    logic [2:0]  in_fn3;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [1:0]  rs_haz;
    logic        unused_bits;

    assign valid       = (ctr_in != 6'd0);
    assign in_rd       = inst_in[11:7];
    assign in_fn3      = inst_in[14:12];
    assign unused_bits = ^{inst_in[31:15], inst_in[6:0]};

    assign misaligned = (in_fn3[1:0] == 2'b10 && alu_in[1:0] != 2'b00) ||
                        (in_fn3[1:0] == 2'b01 && alu_in[0]);

    function automatic logic [31:0] wb_select(input logic [1:0] sel, input logic [31:0] alu,
                                              input logic [29:0] link, input logic [31:0] load);
        case (sel)
            2'b01:   return load;
            2'b10:   return {link, 2'b00};
            default: return alu;
        endcase
    endfunction

    // Next state and the one-cycle events that drive the datapath.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        ack_done  = 1'b0;
        timeout   = 1'b0;
        mis_err   = 1'b0;
        case (state)
            IDLE: begin
                if (valid && ctr_in[1]) begin
                    if (misaligned) begin
                        mis_err = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (ack_flag) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (BUS_TIMEOUT != 0 && cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; only advances with the global enable.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Byte enables and lane-replicated store data for the request being issued.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = rs2_data_in;
        case (in_fn3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << alu_in[1:0];
                wdata_nxt = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << alu_in[1:0];
                wdata_nxt = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        load_byte = ack_data[{lat.addr[1:0], 3'b000} +: 8];
        load_half = ack_data[{lat.addr[1], 4'b0000} +: 16];
        case (lat.fn3)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_val = {{16{load_half[15]}}, load_half};
            3'b100:  load_val = {24'd0, load_byte};
            3'b101:  load_val = {16'd0, load_half};
            default: load_val = ack_data;
        endcase
    end

    // Ack is captured whenever it arrives so a pulse during clk_en=0 is not lost;
    // an ack racing the timeout abort is dropped so it cannot satisfy a later access.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            ack_flag <= 1'b0;
            ack_data <= '0;
        end else if (dbus.ack && dbus.req && !ack_flag && !(clk_en && timeout)) begin
            ack_flag <= 1'b1;
            ack_data <= dbus.rdata;
        end else if (clk_en && ack_done) begin
            ack_flag <= 1'b0;
        end
    end

    // Bus request, access latch and timeout counter.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= '0;
            dbus.be    <= '0;
            dbus.wdata <= '0;
            lat        <= '0;
            cnt        <= '0;
        end else if (clk_en) begin
            if (issue) begin
                dbus.req   <= 1'b1;
                dbus.we    <= ctr_in[2];
                dbus.addr  <= alu_in[31:2];
                dbus.be    <= be_nxt;
                dbus.wdata <= wdata_nxt;
                lat        <= '{reg_write: ctr_in[0], rd: in_rd, fn3: in_fn3,
                                wb_sel: ctr_in[4:3], addr: alu_in, link: inc_pc_in};
                cnt        <= '0;
            end else if (ack_done || timeout) begin
                dbus.req <= 1'b0;
                dbus.we  <= 1'b0;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Registered writeback: plain ALU/link results straight from IDLE, loads on the ack cycle.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (clk_en) begin
            wb_we <= 1'b0;
            if (state == IDLE && valid && !ctr_in[1]) begin
                wb_we   <= ctr_in[0] && in_rd != 5'd0;
                wb_rd   <= in_rd;
                wb_data <= wb_select(ctr_in[4:3], alu_in, inc_pc_in, alu_in);
            end else if (ack_done) begin
                wb_we   <= lat.reg_write && lat.rd != 5'd0;
                wb_rd   <= lat.rd;
                wb_data <= wb_select(lat.wb_sel, lat.addr, lat.link, load_val);
            end
        end
    end

    // Error strobe: always a single-cycle pulse.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= clk_en && (mis_err || timeout);
        end
    end

    // RAW check per execute operand: producer in this stage (input or pending load)
    // or the value being written back this cycle (regfile is not write-through).
    logic [1:0][4:0] rs_addr;
    logic [1:0]      rs_used;
    assign rs_addr = {exe_rs2_address, exe_rs1_address};
    assign rs_used = {exe_uses_rs2, exe_uses_rs1};

    for (genvar n = 0; n < 2; n++) begin : g_haz
        assign rs_haz[n] = rs_used[n] && rs_addr[n] != 5'd0 &&
                           ((ctr_in[0] && rs_addr[n] == in_rd) ||
                            (state == BUSY && lat.reg_write && rs_addr[n] == lat.rd) ||
                            (wb_we && rs_addr[n] == wb_rd));
    end

    assign invalidate  = valid && branch_result_in;
    assign pc_redirect = invalidate;
    assign pc_target   = alu_in[31:2];
    assign stall       = !invalidate && (issue || (state == BUSY && !ack_flag) || (|rs_haz));

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for single-cycle behaviour, scripted
// bus sequences, and scoreboards for bus requests and writebacks.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic [5:0]  ctr_in = '0;
    logic [31:0] inst_in = '0;
    logic [31:0] alu_in = '0;
    logic [29:0] inc_pc_in = '0;
    logic [31:0] rs2_data_in = '0;
    logic        branch_result_in = 1'b0;
    logic [4:0]  exe_rs1_address = '0;
    logic [4:0]  exe_rs2_address = '0;
    logic        exe_uses_rs1 = 1'b0;
    logic        exe_uses_rs2 = 1'b0;
    logic        invalidate, stall, pc_redirect, wb_we, bus_err;
    logic [29:0] pc_target;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    memory_stage_if dbus();

    memory_stage dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .ctr_in(ctr_in),
        .inst_in(inst_in), .alu_in(alu_in), .inc_pc_in(inc_pc_in), .rs2_data_in(rs2_data_in),
        .branch_result_in(branch_result_in), .exe_rs1_address(exe_rs1_address),
        .exe_rs2_address(exe_rs2_address), .exe_uses_rs1(exe_uses_rs1), .exe_uses_rs2(exe_uses_rs2),
        .invalidate(invalidate), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .dbus(dbus), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboards
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_exp_t;
    typedef struct { logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    wb_exp_t  we_e;
    bus_exp_t be_e;
    logic     mon_en = 1'b0;
    logic     req_d = 1'b0;
    logic     en_q = 1'b0;

    always @(posedge clk) en_q <= clk_en;

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_we && en_q) begin
                if (wb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected actual=rd%0d/%h required=no_write", wb_rd, wb_data);
                end else begin
                    we_e = wb_q.pop_front();
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, we_e.rd});
                    check("wb_data", wb_data, we_e.data);
                end
            end
            if (dbus.req && !req_d) begin
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected actual=addr%h required=no_request", dbus.addr);
                end else begin
                    be_e = bus_q.pop_front();
                    check("bus_we", {31'd0, dbus.we}, {31'd0, be_e.we});
                    check("bus_addr", {2'd0, dbus.addr}, {2'd0, be_e.addr});
                    check("bus_be", {28'd0, dbus.be}, {28'd0, be_e.be});
                    check("bus_wdata", dbus.wdata, be_e.wdata);
                end
            end
        end
        req_d <= dbus.req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ctr_in = '0; inst_in = '0; alu_in = '0; inc_pc_in = '0; rs2_data_in = '0;
        branch_result_in = 1'b0; exe_rs1_address = '0; exe_rs2_address = '0;
        exe_uses_rs1 = 1'b0; exe_uses_rs2 = 1'b0;
    endtask

    task automatic drive_mem(input logic [5:0] ctr, input logic [2:0] fn3, input logic [4:0] rd,
                             input logic [31:0] addr, input logic [31:0] sdata);
        bubble();
        ctr_in = ctr; inst_in = {17'd0, fn3, rd, 7'd0}; alu_in = addr; rs2_data_in = sdata;
    endtask

    // Issue an access, ack it in cycle ack_at (0 = issue cycle), count stall cycles.
    task automatic mem_op(input string nm, input logic [5:0] ctr, input logic [2:0] fn3,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                          input int ack_at, input logic [31:0] rdata);
        int n;
        n = 0;
        drive_mem(ctr, fn3, rd, addr, sdata);
        for (int c = 0; c < 400; c++) begin
            #1;
            if (!stall) break;
            n++;
            if (c == ack_at) begin dbus.ack = 1'b1; dbus.rdata = rdata; end
            tick();
            dbus.ack = 1'b0;
            bubble();
        end
        check({nm, "_stalls"}, n, ack_at + 1);
        check({nm, "_req_held"}, {31'd0, dbus.req}, 32'd1);
        tick();
        check({nm, "_req_drop"}, {31'd0, dbus.req}, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  ctr;  logic [4:0] rd;  logic [31:0] alu; logic [29:0] inc; logic br;
        logic [4:0]  rs1;  logic u1; logic [4:0] rs2; logic u2;
        logic        x_stall; logic x_inval; logic [29:0] x_tgt; logic x_wb; logic [31:0] x_wbd;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dbus.ack = 1'b0;
        dbus.rdata = '0;

        vecs[0]  = '{6'b000001, 5'd5, 32'h1111_1111, 30'd0,    1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 30'h0444_4444, 1'b1, 32'h1111_1111};
        vecs[1]  = '{6'b000000, 5'd0, 32'h0,         30'd0,    1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 30'h0,         1'b0, 32'h0};
        vecs[2]  = '{6'b000001, 5'd7, 32'h22,        30'd0,    1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 30'h8,         1'b1, 32'h22};
        vecs[3]  = '{6'b100000, 5'd0, 32'h400,       30'd0,    1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 30'h100,       1'b0, 32'h0};
        vecs[4]  = '{6'b010001, 5'd1, 32'h800,       30'h40,   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 30'h200,       1'b1, 32'h100};
        vecs[5]  = '{6'b000000, 5'd0, 32'h0,         30'd0,    1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 30'h0,         1'b0, 32'h0};
        vecs[6]  = '{6'b000001, 5'd0, 32'h5,         30'd0,    1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 30'h1,         1'b0, 32'h0};
        vecs[7]  = '{6'b000001, 5'd9, 32'hCAFE_0000, 30'd0,    1'b0, 5'd9, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 30'h32BF_8000, 1'b1, 32'hCAFE_0000};
        vecs[8]  = '{6'b100000, 5'd0, 32'h0,         30'd0,    1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 30'h0,         1'b0, 32'h0};
        vecs[9]  = '{6'b000000, 5'd0, 32'h40,        30'd0,    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 30'h10,        1'b0, 32'h0};
        vecs[10] = '{6'b011001, 5'd4, 32'h77,        30'h3,    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 30'h1D,        1'b1, 32'h77};
        vecs[11] = '{6'b000000, 5'd0, 32'h0,         30'd0,    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 30'h0,         1'b0, 32'h0};

        // Reset state
        tick(); tick();
        check("rst_req", {31'd0, dbus.req}, 32'd0);
        check("rst_we", {31'd0, dbus.we}, 32'd0);
        check("rst_addr", {2'd0, dbus.addr}, 32'd0);
        check("rst_be", {28'd0, dbus.be}, 32'd0);
        check("rst_wdata", dbus.wdata, 32'd0);
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_invalidate", {31'd0, invalidate}, 32'd0);
        #2 async_rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single-cycle table: writeback, redirect, hazard stall
        foreach (vecs[i]) begin
            bubble();
            ctr_in = vecs[i].ctr; inst_in = {20'd0, vecs[i].rd, 7'd0}; alu_in = vecs[i].alu;
            inc_pc_in = vecs[i].inc; branch_result_in = vecs[i].br;
            exe_rs1_address = vecs[i].rs1; exe_uses_rs1 = vecs[i].u1;
            exe_rs2_address = vecs[i].rs2; exe_uses_rs2 = vecs[i].u2;
            if (vecs[i].x_wb) wb_q.push_back('{vecs[i].rd, vecs[i].x_wbd});
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].x_stall});
            check($sformatf("v%0d_invalidate", i), {31'd0, invalidate}, {31'd0, vecs[i].x_inval});
            check($sformatf("v%0d_redirect", i), {31'd0, pc_redirect}, {31'd0, vecs[i].x_inval});
            check($sformatf("v%0d_target", i), {2'd0, pc_target}, {2'd0, vecs[i].x_tgt});
            tick();
        end

        // LW 0x104, ack in the third cycle
        bus_q.push_back('{1'b0, 30'h41, 4'b1111, 32'h0});
        wb_q.push_back('{5'd10, 32'hDEAD_BEEF});
        mem_op("lw", 6'b001011, 3'b010, 5'd10, 32'h104, 32'h0, 2, 32'hDEAD_BEEF);

        // LB 0x203 sign-extends
        bus_q.push_back('{1'b0, 30'h80, 4'b1000, 32'h0});
        wb_q.push_back('{5'd11, 32'hFFFF_FF80});
        mem_op("lb", 6'b001011, 3'b000, 5'd11, 32'h203, 32'h0, 1, 32'h8012_3456);

        // LBU 0x203 with the ack landing while clk_en is low
        bus_q.push_back('{1'b0, 30'h80, 4'b1000, 32'h0});
        wb_q.push_back('{5'd12, 32'h0000_0080});
        drive_mem(6'b001011, 3'b100, 5'd12, 32'h203, 32'h0);
        #1 check("lbu_issue_stall", {31'd0, stall}, 32'd1);
        tick(); bubble();
        clk_en = 1'b0; dbus.ack = 1'b1; dbus.rdata = 32'h8012_3456;
        tick(); dbus.ack = 1'b0;
        #1 check("lbu_stall_flag", {31'd0, stall}, 32'd0);
        tick();
        check("lbu_req_frozen", {31'd0, dbus.req}, 32'd1);
        check("lbu_no_wb_frozen", {31'd0, wb_we}, 32'd0);
        clk_en = 1'b1;
        tick();
        check("lbu_req_drop", {31'd0, dbus.req}, 32'd0);
        tick();

        // SH 0x102 and SB 0x101: lane enables and replication, no writeback
        bus_q.push_back('{1'b1, 30'h40, 4'b1100, 32'h1234_1234});
        mem_op("sh", 6'b000110, 3'b001, 5'd0, 32'h102, 32'h0000_1234, 1, 32'h0);
        check("sh_no_wb", {31'd0, wb_we}, 32'd0);
        bus_q.push_back('{1'b1, 30'h40, 4'b0010, 32'hABAB_ABAB});
        mem_op("sb", 6'b000110, 3'b000, 5'd0, 32'h101, 32'h0000_00AB, 3, 32'h0);

        // Misaligned LW and LH: error pulse, no request, no writeback
        drive_mem(6'b001011, 3'b010, 5'd13, 32'h102, 32'h0);
        #1 check("mis_lw_stall", {31'd0, stall}, 32'd0);
        tick(); bubble();
        check("mis_lw_err", {31'd0, bus_err}, 32'd1);
        check("mis_lw_req", {31'd0, dbus.req}, 32'd0);
        tick();
        check("mis_lw_err_pulse", {31'd0, bus_err}, 32'd0);
        drive_mem(6'b001011, 3'b001, 5'd13, 32'h101, 32'h0);
        tick(); bubble();
        check("mis_lh_err", {31'd0, bus_err}, 32'd1);
        tick();

        // Timeout: request held for BUS_TIMEOUT cycles, then error pulse
        bus_q.push_back('{1'b0, 30'h4, 4'b1111, 32'h0});
        drive_mem(6'b001011, 3'b010, 5'd14, 32'h10, 32'h0);
        tick(); bubble();
        n = 0;
        for (int c = 0; c < 600; c++) begin
            if (!dbus.req) break;
            n++;
            tick();
        end
        check("tmo_req_cycles", n, 32'd255);
        check("tmo_err", {31'd0, bus_err}, 32'd1);
        dbus.ack = 1'b1; dbus.rdata = 32'h5555_5555;
        tick(); dbus.ack = 1'b0;
        check("tmo_err_pulse", {31'd0, bus_err}, 32'd0);
        #1 check("tmo_late_ack_stall", {31'd0, stall}, 32'd0);
        tick();

        // Async reset mid-access drops req at once; a later ack is ignored
        bus_q.push_back('{1'b0, 30'h8, 4'b1111, 32'h0});
        drive_mem(6'b001011, 3'b010, 5'd15, 32'h20, 32'h0);
        tick(); bubble(); tick();
        #2 async_rst_n = 1'b0;
        #1 check("arst_req", {31'd0, dbus.req}, 32'd0);
        @(negedge clk) async_rst_n = 1'b1;
        tick();
        dbus.ack = 1'b1; dbus.rdata = 32'h1357_9BDF;
        tick(); dbus.ack = 1'b0;
        tick();
        check("arst_ack_ignored_req", {31'd0, dbus.req}, 32'd0);
        check("arst_ack_ignored_wb", {31'd0, wb_we}, 32'd0);
        bus_q.push_back('{1'b0, 30'hC, 4'b1111, 32'h0});
        wb_q.push_back('{5'd16, 32'h2468_ACE0});
        mem_op("post_rst_lw", 6'b001011, 3'b010, 5'd16, 32'h30, 32'h0, 2, 32'h2468_ACE0);

        tick(); tick();
        check("wb_queue_empty", wb_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
